// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and pointer coding helpers.
package fifo_pkg;

  localparam int FIFO_PTR_WIDTH  = 4;
  localparam int FIFO_ADDR_WIDTH = FIFO_PTR_WIDTH - 1;
  localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;

  typedef logic [FIFO_PTR_WIDTH-1:0] ptr_t;

  // Binary to reflected Gray; adjacent binary values differ in one Gray bit.
  function automatic ptr_t bin2gray(ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(ptr_t g);
    ptr_t b;
    b[FIFO_PTR_WIDTH-1] = g[FIFO_PTR_WIDTH-1];
    for (int i = FIFO_PTR_WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter, XOR prefix chain from the MSB down.
module gray2bin_conv #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin[W-1] = gray[W-1];

  // Each lower bit folds in the already-decoded bit above it.
  for (genvar i = W-2; i >= 0; i--) begin : g_chain
    assign bin[i] = bin[i+1] ^ gray[i];
  end

endmodule

// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer and status for the async FIFO. Owns the binary read
// pointer, publishes a registered Gray copy for the write domain, and derives
// empty / almost_empty / occupancy / underflow from the synchronized Gray
// write pointer. Everything is registered; no input reaches an output
// combinationally.
module fifo_rd_ptr_empty
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = FIFO_PTR_WIDTH,
  parameter int AE_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_inc,
  input  logic [PTR_WIDTH-1:0] wr_ptr_gray_sync,
  input  logic                 clr_underflow,
  output logic [PTR_WIDTH-2:0] rd_addr,
  output logic [PTR_WIDTH-1:0] rd_ptr_gray,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH-1:0] occupancy,
  output logic                 underflow
);

  // Threshold widened by one bit so AE_THRESH == DEPTH still compares cleanly.
  localparam logic [PTR_WIDTH:0] AE_LIM = (PTR_WIDTH+1)'(AE_THRESH);

  logic [PTR_WIDTH-1:0] rd_bin;
  logic [PTR_WIDTH-1:0] rd_bin_next;
  logic [PTR_WIDTH-1:0] rd_gray_next;
  logic [PTR_WIDTH-1:0] wr_bin_sync;
  logic [PTR_WIDTH-1:0] occ_next;
  logic                 pop;
  logic                 under_evt;

  gray2bin_conv #(.W(PTR_WIDTH)) u_wr_g2b (
    .gray (wr_ptr_gray_sync),
    .bin  (wr_bin_sync)
  );

  // Pop qualification and next-pointer / next-status arithmetic. Status is
  // computed from rd_bin_next so a pop and a write-pointer move in the same
  // cycle are both reflected on the following edge.
  always_comb begin
    pop          = rd_inc & ~empty;
    under_evt    = rd_inc & empty;
    rd_bin_next  = rd_bin + {{(PTR_WIDTH-1){1'b0}}, pop};
    rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
    occ_next     = wr_bin_sync - rd_bin_next;
  end

  // Pointer registers: binary and Gray copies move on the same edge, Gray
  // changes in at most one bit because rd_bin steps by at most one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
    end else begin
      rd_bin      <= rd_bin_next;
      rd_ptr_gray <= rd_gray_next;
    end
  end

  // Status registers; empty comes from the Gray compare and agrees with
  // occupancy == 0 because Gray coding is a bijection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      occupancy    <= '0;
    end else begin
      empty        <= (rd_gray_next == wr_ptr_gray_sync);
      almost_empty <= ({1'b0, occ_next} <= AE_LIM);
      occupancy    <= occ_next;
    end
  end

  // Sticky underflow; a new event beats a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                underflow <= 1'b0;
    else if (under_evt)     underflow <= 1'b1;
    else if (clr_underflow) underflow <= 1'b0;
  end

  assign rd_addr = rd_bin[PTR_WIDTH-2:0];

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Self-checking bench for fifo_rd_ptr_empty: hand-written vector table, then
// corner sequences and randomized traffic against a count-based model.
module tb_fifo_rd_ptr_empty;

  localparam int PW    = 4;
  localparam int DEPTH = 8;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_inc;
  logic [PW-1:0] wr_ptr_gray_sync;
  logic          clr_underflow;
  logic [PW-2:0] rd_addr;
  logic [PW-1:0] rd_ptr_gray;
  logic          empty;
  logic          almost_empty;
  logic [PW-1:0] occupancy;
  logic          underflow;

  fifo_rd_ptr_empty #(.PTR_WIDTH(PW), .AE_THRESH(AE)) dut (
    .clk              (clk),
    .rst              (rst),
    .rd_inc           (rd_inc),
    .wr_ptr_gray_sync (wr_ptr_gray_sync),
    .clr_underflow    (clr_underflow),
    .rd_addr          (rd_addr),
    .rd_ptr_gray      (rd_ptr_gray),
    .empty            (empty),
    .almost_empty     (almost_empty),
    .occupancy        (occupancy),
    .underflow        (underflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: absolute counts of entries written and read.
  int m_wr, m_rd, m_occ, m_uf;
  int prev_gray;

  function automatic int gray_of(int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_occ = 0; m_uf = 0; prev_gray = 0;
  endtask

  task automatic check_model();
    chk("occupancy", int'(occupancy), m_occ);
    chk("empty", int'(empty), (m_occ == 0) ? 1 : 0);
    chk("almost_empty", int'(almost_empty), (m_occ <= AE) ? 1 : 0);
    chk("underflow", int'(underflow), m_uf);
    chk("rd_addr", int'(rd_addr), m_rd % DEPTH);
    chk("rd_ptr_gray", int'(rd_ptr_gray), gray_of(m_rd % 16));
    chk("gray_one_bit", ($countones(rd_ptr_gray ^ PW'(prev_gray)) <= 1) ? 1 : 0, 1);
    prev_gray = int'(rd_ptr_gray);
  endtask

  // One clock: drive inputs, advance model, sample 1ns after the edge.
  task automatic step(input bit inc, input int wr, input bit clr, input bit do_chk);
    bit p;
    assert (wr - m_rd <= DEPTH && wr >= m_rd)
      else $error("illegal write pointer: implies occupancy %0d", wr - m_rd);
    rd_inc = inc;
    clr_underflow = clr;
    wr_ptr_gray_sync = PW'(gray_of(wr % 16));
    m_wr = wr;
    p = inc && (m_occ != 0);
    if (inc && m_occ == 0) m_uf = 1;
    else if (clr) m_uf = 0;
    m_rd += int'(p);
    m_occ = m_wr - m_rd;
    @(posedge clk);
    #1;
    if (do_chk) check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_inc = 0; clr_underflow = 0; wr_ptr_gray_sync = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit inc; int wr; bit clr;
    int occ; bit emp; bit ae; bit uf; int addr; int gray;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // rd_inc, wr(bin), clr | occ, empty, ae, uf, addr, gray
    vecs[0]  = '{0, 4, 0, 4, 0, 0, 0, 0, 4'b0000};
    vecs[1]  = '{1, 4, 0, 3, 0, 0, 0, 1, 4'b0001};
    vecs[2]  = '{1, 4, 0, 2, 0, 0, 0, 2, 4'b0011};
    vecs[3]  = '{1, 4, 0, 1, 0, 1, 0, 3, 4'b0010};
    vecs[4]  = '{1, 4, 0, 0, 1, 1, 0, 4, 4'b0110};
    vecs[5]  = '{1, 4, 0, 0, 1, 1, 1, 4, 4'b0110};
    vecs[6]  = '{1, 4, 1, 0, 1, 1, 1, 4, 4'b0110};
    vecs[7]  = '{0, 4, 1, 0, 1, 1, 0, 4, 4'b0110};
    vecs[8]  = '{0, 5, 0, 1, 0, 1, 0, 4, 4'b0110};
    vecs[9]  = '{1, 6, 0, 1, 0, 1, 0, 5, 4'b0111};
    vecs[10] = '{1, 6, 0, 0, 1, 1, 0, 6, 4'b0101};
    vecs[11] = '{0, 14, 0, 8, 0, 0, 0, 6, 4'b0101};
    vecs[12] = '{1, 14, 0, 7, 0, 0, 0, 7, 4'b0100};
    vecs[13] = '{1, 14, 0, 6, 0, 0, 0, 0, 4'b1100};

    rst = 1'b1; rd_inc = 0; clr_underflow = 0; wr_ptr_gray_sync = '0;
    #2;
    chk("async_rst_empty", int'(empty), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Reset / idle values
    @(posedge clk); #1;
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_underflow", int'(underflow), 0);
    chk("rst_gray", int'(rd_ptr_gray), 0);
    chk("rst_addr", int'(rd_addr), 0);

    // Vector table against hand-derived constants
    foreach (vecs[i]) begin
      rd_inc = vecs[i].inc;
      clr_underflow = vecs[i].clr;
      wr_ptr_gray_sync = PW'(gray_of(vecs[i].wr));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_occ", i), int'(occupancy), vecs[i].occ);
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].emp));
      chk($sformatf("vec%0d_ae", i), int'(almost_empty), int'(vecs[i].ae));
      chk($sformatf("vec%0d_uf", i), int'(underflow), int'(vecs[i].uf));
      chk($sformatf("vec%0d_addr", i), int'(rd_addr), vecs[i].addr);
      chk($sformatf("vec%0d_gray", i), int'(rd_ptr_gray), vecs[i].gray);
    end

    // Async reset mid-operation, checked before any clock edge
    rst = 1'b1;
    #1;
    chk("mid_rst_occ", int'(occupancy), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_ae", int'(almost_empty), 1);
    chk("mid_rst_gray", int'(rd_ptr_gray), 0);
    chk("mid_rst_addr", int'(rd_addr), 0);
    do_reset();

    // Full FIFO then seven pops
    step(0, 8, 0, 1);
    chk("full_occ", int'(occupancy), 8);
    for (int i = 0; i < 7; i++) step(1, 8, 0, 1);
    chk("seven_pops_ae", int'(almost_empty), 1);
    chk("seven_pops_empty", int'(empty), 0);
    do_reset();

    // Wrap-around: 16 pops with the write pointer running 8..15,0
    step(0, 8, 0, 1);
    for (int i = 0; i < 16; i++) step(1, (8 + i > 16) ? 16 : 8 + i, 0, 1);
    chk("wrap_gray_home", int'(rd_ptr_gray), 0);
    chk("wrap_pops", m_rd, 16);
    do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int w;
      w = m_wr;
      if ($urandom_range(0, 2) != 0 && (w + 1 - m_rd) <= DEPTH) w++;
      step(1'($urandom_range(0, 1)), w, ($urandom_range(0, 7) == 0), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
